cpu16_wb_master: RTL and testbench
==================================

// Module: cpu16_wb_master
// PURPOSE
//   Wishbone (pipelined) bus initiator between CPU16 and the byte-wide board I/O responder.
//   Decodes CPU accesses to the I/O page and issues single Wishbone cycles.
//   Holds the CPU until the responder acks or a timeout expires.
//   Returns zero-extended read data to the system memory-map mux.
//   Replaces the fixed-strobe hookup so stalling and late-ack responders work.
// PARAMETERS
//   IO_PAGE   8'h20  cpu_addr[15:8] value that selects the I/O page
//   TIMEOUT   255    max cycles from REQ entry to ack before abort (1..255)
// PORTS
//   clk        in   1   system clock, all state on rising edge
//   reset      in   1   asynchronous, active-low reset
//   cpu_addr   in   16  CPU address, valid while CPU is held
//   cpu_dout   in   16  CPU write data; bits [7:0] used
//   cpu_we     in   1   CPU write enable
//   cpu_hold   out  1   stall request to CPU16 hold input
//   io_din     out  16  read data to memory-map mux, {8'h00, rdata}
//   wb_cyc     out  1   Wishbone cycle
//   wb_stb     out  1   Wishbone strobe
//   wb_we      out  1   Wishbone write enable
//   wb_addr    out  8   Wishbone address, registered cpu_addr[7:0]
//   wb_dat_o   out  8   Wishbone write data, registered cpu_dout[7:0]
//   wb_dat_i   in   8   Wishbone read data, sampled on wb_ack
//   wb_stall   in   1   responder not accepting strobe
//   wb_ack     in   1   responder completion
//   bus_err    out  1   sticky timeout flag
//   err_clr    in   1   clears bus_err
// BEHAVIOUR
//   Reset: state=IDLE; wb_cyc, wb_stb, wb_we, bus_err = 0; wb_addr, wb_dat_o, rdata, timer = 0.
//   Reset is asynchronous: an assertion mid-cycle drops cyc/stb at once; no ack is awaited.
//   sel = (cpu_addr[15:8]==IO_PAGE).
//   cpu_hold = sel & (state!=DONE), combinational; it is 0 in reset.
//   IDLE: if sel, register addr/we/dat, clear timer, go to REQ. Otherwise stay.
//   REQ: cyc=1, stb=1; timer increments each cycle.
//     - stall=1: stay, with stb held and addr/dat/we stable.
//     - stall=0, ack=0: strobe accepted; go to WAIT.
//     - stall=0, ack=1: accept and complete in the same cycle; go to DONE.
//   WAIT: cyc=1, stb=0; timer increments; ack=1 goes to DONE.
//   Completion: on ack, a read latches rdata=wb_dat_i and a write leaves rdata unchanged.
//   Timeout: timer==TIMEOUT in REQ or WAIT without ack forces DONE.
//     rdata=8'hFF; bus_err set; cyc/stb drop next cycle.
//     If ack and timeout coincide, ack wins (normal completion, no error).
//   DONE: cyc=0, stb=0, cpu_hold=0 for exactly one cycle so the CPU advances; then IDLE.
//   Back-to-back: if sel is still high in the IDLE cycle after DONE, it is a new access.
//   A stray ack in IDLE or DONE is ignored.
//   io_din = {8'h00, rdata}; it is valid in the DONE cycle and holds until the next completion.
//   bus_err: set has priority over err_clr in the same cycle; otherwise err_clr clears it.
//   Minimum latency, zero-wait responder (stall=0, ack 1 cycle after stb):
//     IDLE -> REQ -> WAIT -> DONE; cpu_hold high for 3 cycles.
// TESTING
//   1. Read 0x2000; stall=0; ack+dat_i=8'h5A one cycle after stb
//      -> one stb pulse, wb_addr=8'h00, cpu_hold high 3 cycles, io_din=16'h005A in DONE.
//   2. Write 0x2005, dout=16'h12C3; stall high 4 cycles
//      -> stb high 5 cycles, wb_dat_o=8'hC3 and wb_we=1 stable throughout; single ack completes.
//   3. Read 0x2002; ack asserted in the same cycle stall drops
//      -> REQ->DONE directly, WAIT skipped, io_din=16'h00<dat_i>.
//   4. TIMEOUT=8; responder never acks
//      -> DONE after 8 cycles, io_din=16'h00FF, bus_err=1.
//      err_clr pulse -> bus_err=0; err_clr held during a second timeout -> bus_err stays 1.
//   5. reset low while in WAIT
//      -> wb_cyc/wb_stb 0 before the next edge; after release, state IDLE.
//      A late ack is ignored; no spurious DONE.
//   6. Access 0x1000 or 0xF123
//      -> no cyc/stb, cpu_hold=0; then back-to-back 0x2000 reads both complete with 2 stb pulses.

Source files
------------

// File: rtl/cpu16_wb_master.sv
// Pipelined Wishbone initiator for CPU16 accesses to the byte-wide I/O page.
// Single cycle per CPU access; the CPU is held until ack or timeout.
module cpu16_wb_master #(
    parameter logic [7:0] IO_PAGE = 8'h20,
    parameter int         TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic        cpu_we,
    output logic        cpu_hold,
    output logic [15:0] io_din,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [7:0]  wb_addr,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_stall,
    input  logic        wb_ack,
    output logic        bus_err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] rdata;
    logic [7:0] timer;
    logic [7:0] timer_inc;
    logic       sel;
    logic       expire;
    logic       unused_bits;

    assign sel         = (cpu_addr[15:8] == IO_PAGE);
    assign timer_inc   = timer + 8'd1;
    // timer_inc counts busy cycles including the current one, so an access
    // gets exactly TIMEOUT cycles in REQ/WAIT before it is aborted.
    assign expire      = (timer_inc == TO);
    assign cpu_hold    = reset & sel & (state != DONE);
    assign io_din      = {8'h00, rdata};
    assign unused_bits = ^cpu_dout[15:8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= 8'h00;
            wb_dat_o <= 8'h00;
            rdata    <= 8'h00;
            timer    <= 8'h00;
            bus_err  <= 1'b0;
        end else begin
            // A timeout below overrides this clear in the same cycle.
            if (err_clr) bus_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel) begin
                        wb_addr  <= cpu_addr[7:0];
                        wb_dat_o <= cpu_dout[7:0];
                        wb_we    <= cpu_we;
                        timer    <= 8'h00;
                        wb_cyc   <= 1'b1;
                        wb_stb   <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    timer <= timer_inc;
                    if (!wb_stall && wb_ack) begin
                        if (!wb_we) rdata <= wb_dat_i;
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        state  <= DONE;
                    end else if (expire) begin
                        rdata   <= 8'hFF;
                        bus_err <= 1'b1;
                        wb_cyc  <= 1'b0;
                        wb_stb  <= 1'b0;
                        state   <= DONE;
                    end else if (!wb_stall) begin
                        wb_stb <= 1'b0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer_inc;
                    if (wb_ack) begin
                        if (!wb_we) rdata <= wb_dat_i;
                        wb_cyc <= 1'b0;
                        state  <= DONE;
                    end else if (expire) begin
                        rdata   <= 8'hFF;
                        bus_err <= 1'b1;
                        wb_cyc  <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu16_wb_master.sv
// Bench for cpu16_wb_master: directed vector table, hand-written corner sequences
// and random accesses checked against a transaction-level model.
module tb_cpu16_wb_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cpu_addr = 16'h2000;
    logic [15:0] cpu_dout = 16'h0000;
    logic        cpu_we = 1'b0;
    logic        cpu_hold;
    logic [15:0] io_din;
    logic        wb_cyc, wb_stb, wb_we;
    logic [7:0]  wb_addr, wb_dat_o;
    logic [7:0]  wb_dat_i = 8'h00;
    logic        wb_stall = 1'b0;
    logic        wb_ack = 1'b0;
    logic        bus_err;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] m_rdata = 8'h00;
    bit         m_err = 1'b0;

    cpu16_wb_master #(.IO_PAGE(8'h20), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_we(cpu_we), .cpu_hold(cpu_hold), .io_din(io_din),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_stall(wb_stall),
        .wb_ack(wb_ack), .bus_err(bus_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // One access plus the responder behaviour it sees and the expected outcome.
    typedef struct {
        logic [15:0] addr;
        bit          we;
        logic [15:0] dout;
        logic [7:0]  dat;
        int          stall_n;
        bit          same;
        int          delay;
        bit          never;
        int          exp_hold;
        int          exp_stb;
        logic [15:0] exp_din;
        bit          exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outcome from the access rules: busy cycles are REQ+WAIT cycles, capped at TO.
    function automatic vec_t model(input vec_t v, input bit clr);
        int  n_req, n_full, busy;
        bit  tmo;
        n_req  = v.stall_n + 1;
        n_full = v.never ? 1000 : (v.same ? n_req : n_req + v.delay);
        tmo    = (n_full > TO);
        busy   = tmo ? TO : n_full;
        v.exp_hold = busy + 1;
        v.exp_stb  = (n_req < busy) ? n_req : busy;
        v.exp_din  = {8'h00, tmo ? 8'hFF : (v.we ? m_rdata : v.dat)};
        v.exp_err  = tmo ? 1'b1 : (clr ? 1'b0 : m_err);
        return v;
    endfunction

    // Starts in an IDLE cycle; plays responder; returns in the DONE cycle.
    task automatic run_txn(input string tag, input vec_t v);
        int hold_cnt = 0;
        int stb_cnt  = 0;
        int busy     = 0;
        bit stable   = 1'b1;
        bit done     = 1'b0;
        @(negedge clk);
        cpu_addr = v.addr;
        cpu_we   = v.we;
        cpu_dout = v.dout;
        for (int i = 0; i < 100 && !done; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (!cpu_hold) begin
                done     = 1'b1;
                wb_ack   = 1'b0;
                wb_stall = 1'b0;
                chk({tag, " hold_cycles"}, hold_cnt, v.exp_hold);
                chk({tag, " stb_cycles"}, stb_cnt, v.exp_stb);
                chk({tag, " io_din"}, io_din, v.exp_din);
                chk({tag, " bus_err"}, bus_err, v.exp_err);
                chk({tag, " cyc_in_done"}, wb_cyc, 0);
                chk({tag, " req_stable"}, stable, 1);
            end else begin
                hold_cnt++;
                if (wb_cyc) begin
                    busy++;
                    if (wb_stb) begin
                        stb_cnt++;
                        if (wb_addr !== v.addr[7:0] || wb_we !== v.we ||
                            wb_dat_o !== v.dout[7:0]) stable = 1'b0;
                        wb_stall = (stb_cnt <= v.stall_n);
                        wb_ack   = (stb_cnt == v.stall_n + 1) && v.same && !v.never;
                    end else begin
                        wb_stall = 1'b0;
                        wb_ack   = !v.never && !v.same && (busy - (v.stall_n + 1) == v.delay);
                    end
                end else begin
                    wb_stall = 1'b0;
                    wb_ack   = 1'($urandom_range(0, 1));  // stray ack while idle
                end
                wb_dat_i = (wb_ack && wb_cyc) ? v.dat : 8'($urandom);
            end
        end
        if (!done) chk({tag, " completed"}, 0, 1);
    endtask

    task automatic idle_check(input string tag, input logic [15:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cpu_addr = a;
            #1;
            chk({tag, " no_cyc"}, {wb_cyc, wb_stb}, 2'b00);
            chk({tag, " no_hold"}, cpu_hold, 0);
        end
    endtask

    initial begin
        vec_t v;
        bit   found;

        tbl[0] = '{16'h2000, 1'b0, 16'h0000, 8'h5A, 0, 1'b0, 1, 1'b0, 3, 1, 16'h005A, 1'b0};
        tbl[1] = '{16'h2005, 1'b1, 16'h12C3, 8'hEE, 4, 1'b0, 1, 1'b0, 7, 5, 16'h005A, 1'b0};
        tbl[2] = '{16'h2002, 1'b0, 16'h0000, 8'h3C, 2, 1'b1, 1, 1'b0, 4, 3, 16'h003C, 1'b0};
        tbl[3] = '{16'h2010, 1'b0, 16'h0000, 8'h99, 0, 1'b0, 1, 1'b1, 9, 1, 16'h00FF, 1'b1};
        tbl[4] = '{16'h2011, 1'b0, 16'h0000, 8'h77, 3, 1'b0, 4, 1'b0, 9, 4, 16'h0077, 1'b1};
        tbl[5] = '{16'h2012, 1'b1, 16'hAB34, 8'h00, 9, 1'b0, 1, 1'b1, 9, 8, 16'h00FF, 1'b1};

        // Reset state, with an I/O address presented
        #12;
        chk("rst cyc_stb_we", {wb_cyc, wb_stb, wb_we}, 3'b000);
        chk("rst hold", cpu_hold, 0);
        chk("rst io_din", io_din, 16'h0000);
        chk("rst bus_err", bus_err, 0);
        chk("rst addr_dat", {wb_addr, wb_dat_o}, 16'h0000);
        @(negedge clk);
        cpu_addr = 16'h1000;
        reset    = 1'b1;

        foreach (tbl[i]) begin
            run_txn($sformatf("vec%0d", i), tbl[i]);
            cpu_addr = 16'h1000;
            m_rdata  = tbl[i].exp_din[7:0];
            m_err    = tbl[i].exp_err;
        end

        // err_clr pulse clears; held err_clr loses to a timeout set
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1 chk("err_clr pulse", bus_err, 0);
        err_clr = 1'b1;
        v = '{16'h2020, 1'b0, 16'h0000, 8'h00, 0, 1'b0, 1, 1'b1, 9, 1, 16'h00FF, 1'b1};
        run_txn("tmo_clr_held", v);
        cpu_addr = 16'h1000;
        @(negedge clk);
        err_clr = 1'b0;
        #1 chk("err_clr after done", bus_err, 0);
        m_rdata = 8'hFF;
        m_err   = 1'b0;

        // Non-I/O accesses, then back-to-back reads of 0x2000
        idle_check("addr1000", 16'h1000, 3);
        idle_check("addrF123", 16'hF123, 3);
        v = '{16'h2000, 1'b0, 16'h0000, 8'h11, 0, 1'b0, 1, 1'b0, 3, 1, 16'h0011, 1'b0};
        run_txn("b2b_a", v);
        v = '{16'h2000, 1'b0, 16'h0000, 8'h22, 0, 1'b0, 1, 1'b0, 3, 1, 16'h0022, 1'b0};
        run_txn("b2b_b", v);
        cpu_addr = 16'h1000;

        // Reset asserted while waiting for ack; late ack afterwards is ignored
        @(negedge clk);
        cpu_addr = 16'h2003;
        cpu_we   = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            #1;
            if (wb_cyc && !wb_stb) found = 1'b1;
        end
        chk("reached wait", found, 1);
        reset = 1'b0;
        #1;
        chk("async rst cyc_stb", {wb_cyc, wb_stb}, 2'b00);
        chk("async rst hold", cpu_hold, 0);
        @(negedge clk);
        reset    = 1'b1;
        cpu_addr = 16'h1000;
        wb_ack   = 1'b1;
        wb_dat_i = 8'hC7;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("late ack no_cyc", {wb_cyc, wb_stb}, 2'b00);
            chk("late ack no_hold", cpu_hold, 0);
        end
        chk("late ack io_din", io_din, 16'h0000);
        chk("late ack bus_err", bus_err, 0);
        wb_ack  = 1'b0;
        m_rdata = 8'h00;
        m_err   = 1'b0;
        v = '{16'h2001, 1'b0, 16'h0000, 8'h6B, 0, 1'b0, 1, 1'b0, 3, 1, 16'h006B, 1'b0};
        run_txn("post_rst", v);
        m_rdata = 8'h6B;

        // Random accesses against the model
        for (int n = 0; n < 40; n++) begin
            v.addr    = {8'h20, 8'($urandom)};
            v.we      = 1'($urandom_range(0, 1));
            v.dout    = 16'($urandom);
            v.dat     = 8'($urandom);
            v.stall_n = $urandom_range(0, 5);
            v.same    = 1'($urandom_range(0, 1));
            v.delay   = $urandom_range(1, 5);
            v.never   = ($urandom_range(0, 7) == 0);
            v = model(v, 1'b0);
            run_txn($sformatf("rnd%0d", n), v);
            m_rdata = v.exp_din[7:0];
            m_err   = v.exp_err;
            if ($urandom_range(0, 2) != 0) begin
                cpu_addr = $urandom_range(0, 1) ? 16'h1000 : 16'hF123;
                for (int g = 0; g < $urandom_range(1, 3); g++) begin
                    @(negedge clk);
                    err_clr = ($urandom_range(0, 3) == 0);
                    if (err_clr) m_err = 1'b0;
                    #1 chk("gap idle", {wb_cyc, cpu_hold}, 2'b00);
                end
                @(negedge clk);
                err_clr = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
